// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and helpers for the programmable sequence detector
package seq_det_pkg;

    typedef enum logic [1:0] {
        DISABLED,
        FILL,
        RUN
    } det_state_t;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Ones in the low len bits; upper pattern/history bits never take part in a compare.
    function automatic logic [63:0] len_mask(input int len);
        return (64'd1 << len) - 64'd1;
    endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// rtl/seq_det_sat_counter.sv - saturating up-counter, holds at all-ones
module seq_det_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - runtime-programmable serial pattern detector, Mealy match flag
// Optional match counter built when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_0110,
    parameter int                 RST_LEN     = 4,
    parameter int                 CNT_W       = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             x,
    input  logic                             x_valid,
    input  logic                             cfg_load,
    input  logic [MAX_LEN-1:0]               cfg_pattern,
    input  logic [len_width(MAX_LEN)-1:0]    cfg_len,
    input  logic                             cfg_overlap,
    output logic                             z,
    output logic [CNT_W-1:0]                 match_cnt
);

    localparam int             LW        = len_width(MAX_LEN);
    localparam logic [LW-1:0]  MAX_LEN_L = LW'(MAX_LEN);
    localparam logic [LW-1:0]  ONE       = LW'(1);

    det_state_t         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, window, mask;
    logic [LW-1:0]      len_q, len_d, fill_q, fill_d, cfg_len_c;
    logic               ovl_q, ovl_d, hit;

    function automatic det_state_t state_for_len(input logic [LW-1:0] len);
        if (len == '0) return DISABLED;
        if (len == ONE) return RUN;
        return FILL;
    endfunction

    assign cfg_len_c = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
    assign window    = {hist_q[MAX_LEN-2:0], x};
    assign mask      = MAX_LEN'(len_mask(int'(len_q)));
    assign hit       = ((window ^ pat_q) & mask) == '0;
    assign z         = (state_q == RUN) && x_valid && !cfg_load && hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_q   <= RST_PATTERN;
            len_q   <= LW'(RST_LEN);
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= (RST_LEN > 0) ? RUN : DISABLED;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        if (cfg_load) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len_c;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = state_for_len(cfg_len_c);
        end else if (x_valid) begin
            case (state_q)
                FILL: begin
                    hist_d = window;
                    fill_d = fill_q + ONE;
                    if ((fill_q + ONE) >= (len_q - ONE)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // Non-overlap restarts collection; a 1-bit pattern has nothing to refill.
                    if (z && !ovl_q && (len_q != ONE)) begin
                        hist_d  = '0;
                        fill_d  = '0;
                        state_d = FILL;
                    end else begin
                        hist_d = window;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    seq_det_sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (z),
        .count (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - directed self-checking bench for seq_detector_prog
module tb_seq_detector_prog;

    localparam int ML = 8;
`ifdef SEQ_DET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        x = 1'b0;
    logic        x_valid = 1'b0;
    logic        cfg_load = 1'b0;
    logic        cfg_overlap = 1'b0;
    logic [7:0]  cfg_pattern = '0;
    logic [3:0]  cfg_len = '0;
    logic        z, z2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detector_prog u_dut (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .z(z), .match_cnt(cnt)
    );

    seq_detector_prog #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .z(z2), .match_cnt(cnt2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: history as an integer of accepted bits, armed once len-1 bits have arrived.
    int m_pat = 6, m_len = 4, m_n = ML, m_hist = 0, m_cnt = 0, m_cnt2 = 0;
    bit m_ovl = 1'b1;
    bit started = 1'b0;

    function automatic bit model_z();
        if (!rst || !x_valid || cfg_load || m_len == 0 || m_n < m_len - 1) return 1'b0;
        return ((m_hist * 2 + int'(x)) % (1 << m_len)) == (m_pat % (1 << m_len));
    endfunction

    always begin
        bit ez;
        @(negedge clk);
        #4;
        ez = model_z();
        if (started) begin
            if (rst) begin
                chk("z_model", z, ez);
                chk("z2_model", z2, ez);
            end
            chk("cnt_model", cnt, m_cnt);
            chk("cnt2_model", cnt2, m_cnt2);
        end
        if (!rst) begin
            m_pat = 6; m_len = 4; m_ovl = 1'b1; m_hist = 0; m_n = ML;
            m_cnt = 0; m_cnt2 = 0; started = 1'b1;
        end else if (cfg_load) begin
            m_pat  = int'(cfg_pattern);
            m_len  = (int'(cfg_len) > ML) ? ML : int'(cfg_len);
            m_ovl  = cfg_overlap;
            m_hist = 0;
            m_n    = 0;
        end else if (x_valid && m_len > 0) begin
            if (ez && CNT_EN) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (ez && !m_ovl && m_len > 1) begin
                m_hist = 0;
                m_n    = 0;
            end else begin
                m_hist = (m_hist * 2 + int'(x)) % 256;
                if (m_n < ML) m_n++;
            end
        end
    end

    task automatic drv(input bit xb, input bit vb, input bit ez);
        @(negedge clk);
        rst = 1'b1; cfg_load = 1'b0; x = xb; x_valid = vb;
        #3;
        chk("z_lit", z, ez);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
        @(negedge clk);
        cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        x = 1'b1; x_valid = 1'b1;
        #3;
        chk("z_load", z, 0);
    endtask

    task automatic stream(input logic [15:0] bits, input logic [15:0] ez, input int n);
        for (int i = n - 1; i >= 0; i--) drv(bits[i], 1'b1, ez[i]);
    endtask

    task automatic cnt_lit(input int e16, input int e2);
        @(negedge clk);
        cfg_load = 1'b0; x_valid = 1'b0;
        #3;
        chk("cnt_lit", cnt, CNT_EN ? e16 : 0);
        chk("cnt2_lit", cnt2, CNT_EN ? e2 : 0);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        #3;
        chk("rst_cnt", cnt, 0);
        chk("rst_cnt2", cnt2, 0);
        chk("rst_z", z, 0);

        stream(16'b0110110, 16'b0001001, 7);
        cnt_lit(2, 2);

        load(8'b101, 4'd3, 1'b0);
        stream(16'b10101, 16'b00100, 5);
        cnt_lit(3, 3);

        load(8'b101, 4'd3, 1'b1);
        stream(16'b10101, 16'b00101, 5);
        cnt_lit(5, 3);

        load(8'b0110, 4'd4, 1'b1);
        drv(1'b0, 1'b1, 1'b0);
        drv(1'b1, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 1'b1);
        cnt_lit(6, 3);

        stream(16'b011, 16'b000, 3);
        load(8'b0, 4'd0, 1'b1);
        stream(16'b01100110, 16'b0, 8);
        load(8'b0110, 4'd4, 1'b1);
        stream(16'b1100110, 16'b0000001, 7);
        cnt_lit(7, 3);

        load(8'b10110011, 4'd12, 1'b0);
        stream(16'b10110011, 16'b00000001, 8);
        cnt_lit(8, 3);

        load(8'b10101011, 4'd1, 1'b0);
        stream(16'b1101, 16'b1101, 4);
        cnt_lit(11, 3);

        load(8'b0110, 4'd4, 1'b1);
        stream(16'b011, 16'b000, 3);
        @(negedge clk);
        rst = 1'b0; cfg_load = 1'b0; x = 1'b0; x_valid = 1'b0;
        drv(1'b0, 1'b1, 1'b0);
        cnt_lit(0, 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
